// File: rtl/rise_fall_delay_meter.sv
// Rise/fall propagation-delay meter for a delay-modelled gate stage.
// Both inputs go through identical synchronizers so their latency cancels;
// the FSM counts clock cycles between a stimulus edge and the matching
// response edge and also flags swallowed pulses and missing responses.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | waiting for a stimulus edge
// WAIT_RISE | stimulus rose, counting until the response rises
// WAIT_FALL | stimulus fell, counting until the response falls
module rise_fall_delay_meter #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             stim_in,
    input  logic             resp_in,
    output logic [CNT_W-1:0] rise_dly,
    output logic [CNT_W-1:0] fall_dly,
    output logic             rise_vld,
    output logic             fall_vld,
    output logic             timeout,
    output logic             swallowed,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        WAIT_FALL = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] stim_sync_q;
    logic [SYNC_STAGES-1:0] resp_sync_q;
    logic                   stim_prev_q;
    logic                   resp_prev_q;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       rise_dly_q;
    logic [CNT_W-1:0]       fall_dly_q;
    logic                   rise_vld_q;
    logic                   fall_vld_q;
    logic                   timeout_q;
    logic                   swallowed_q;

    logic stim_s, resp_s;
    logic stim_rise, stim_fall, resp_rise, resp_fall;

    // Synchronizers plus one history flop per input; they run regardless of enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stim_sync_q <= '0;
            resp_sync_q <= '0;
            stim_prev_q <= 1'b0;
            resp_prev_q <= 1'b0;
        end else begin
            stim_sync_q <= {stim_sync_q[SYNC_STAGES-2:0], stim_in};
            resp_sync_q <= {resp_sync_q[SYNC_STAGES-2:0], resp_in};
            stim_prev_q <= stim_s;
            resp_prev_q <= resp_s;
        end
    end

    assign stim_s    = stim_sync_q[SYNC_STAGES-1];
    assign resp_s    = resp_sync_q[SYNC_STAGES-1];
    assign stim_rise =  stim_s & ~stim_prev_q;
    assign stim_fall = ~stim_s &  stim_prev_q;
    assign resp_rise =  resp_s & ~resp_prev_q;
    assign resp_fall = ~resp_s &  resp_prev_q;

    // Measurement FSM with registered results and one-cycle strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rise_dly_q  <= '0;
            fall_dly_q  <= '0;
            rise_vld_q  <= 1'b0;
            fall_vld_q  <= 1'b0;
            timeout_q   <= 1'b0;
            swallowed_q <= 1'b0;
        end else begin
            rise_vld_q  <= 1'b0;
            fall_vld_q  <= 1'b0;
            timeout_q   <= 1'b0;
            swallowed_q <= 1'b0;
            if (!enable) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (stim_rise) begin
                            if (resp_rise) begin
                                rise_dly_q <= '0;
                                rise_vld_q <= 1'b1;
                            end else begin
                                state_q <= WAIT_RISE;
                                cnt_q   <= CNT_W'(1);
                            end
                        end else if (stim_fall) begin
                            if (resp_fall) begin
                                fall_dly_q <= '0;
                                fall_vld_q <= 1'b1;
                            end else begin
                                state_q <= WAIT_FALL;
                                cnt_q   <= CNT_W'(1);
                            end
                        end
                    end
                    WAIT_RISE: begin
                        if (resp_rise) begin
                            rise_dly_q <= cnt_q;
                            rise_vld_q <= 1'b1;
                            state_q    <= IDLE;
                        end else if (stim_fall) begin
                            swallowed_q <= 1'b1;
                            state_q     <= IDLE;
                        end else if (cnt_q == '1) begin
                            timeout_q <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    WAIT_FALL: begin
                        if (resp_fall) begin
                            fall_dly_q <= cnt_q;
                            fall_vld_q <= 1'b1;
                            state_q    <= IDLE;
                        end else if (stim_rise) begin
                            swallowed_q <= 1'b1;
                            state_q     <= IDLE;
                        end else if (cnt_q == '1) begin
                            timeout_q <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign rise_dly  = rise_dly_q;
    assign fall_dly  = fall_dly_q;
    assign rise_vld  = rise_vld_q;
    assign fall_vld  = fall_vld_q;
    assign timeout   = timeout_q;
    assign swallowed = swallowed_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rise_fall_delay_meter.sv
// Bench for rise_fall_delay_meter: directed scenarios plus random trials,
// each trial's outcome derived from the delay/revert/timeout rules.
module tb_rise_fall_delay_meter;

    localparam int CNT_W = 4;
    localparam int S     = 2;
    localparam int MAXD  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic             stim_in;
    logic             resp_in;
    logic [CNT_W-1:0] rise_dly;
    logic [CNT_W-1:0] fall_dly;
    logic             rise_vld;
    logic             fall_vld;
    logic             timeout;
    logic             swallowed;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    logic             lvl;
    logic [CNT_W-1:0] exp_rise;
    logic [CNT_W-1:0] exp_fall;

    rise_fall_delay_meter #(.CNT_W(CNT_W), .SYNC_STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .stim_in   (stim_in),
        .resp_in   (resp_in),
        .rise_dly  (rise_dly),
        .fall_dly  (fall_dly),
        .rise_vld  (rise_vld),
        .fall_vld  (fall_vld),
        .timeout   (timeout),
        .swallowed (swallowed),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string ctx, input logic rv, input logic fv,
                           input logic to, input logic sw, input logic bz);
        chk({ctx, " rise_vld"},  32'(rise_vld),  32'(rv));
        chk({ctx, " fall_vld"},  32'(fall_vld),  32'(fv));
        chk({ctx, " timeout"},   32'(timeout),   32'(to));
        chk({ctx, " swallowed"}, 32'(swallowed), 32'(sw));
        chk({ctx, " busy"},      32'(busy),      32'(bz));
        chk({ctx, " rise_dly"},  32'(rise_dly),  32'(exp_rise));
        chk({ctx, " fall_dly"},  32'(fall_dly),  32'(exp_fall));
    endtask

    task automatic idle_cycles(input string ctx, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            chk_all(ctx, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // d: response delay in sample edges (-1 = never), e: stimulus revert edge (-1 = never)
    task automatic run_trial(input string ctx, input int d, input int e);
        logic dir;
        int   kind;   // 0 measured, 1 swallowed, 2 timeout
        int   outidx;
        logic pv;
        dir = ~lvl;
        if (d >= 0 && d <= MAXD && (e < 0 || d <= e)) begin
            kind = 0; outidx = d;
        end else if (e >= 1 && e <= MAXD) begin
            kind = 1; outidx = e;
        end else begin
            kind = 2; outidx = MAXD;
        end
        for (int i = 0; i <= outidx + S + 2; i++) begin
            @(negedge clk);
            if (i == 0) stim_in = dir;
            if (i == d && i <= outidx) resp_in = dir;
            if (i == e && i <= outidx) stim_in = ~dir;
            @(posedge clk); #1;
            pv = (i == outidx + S);
            if (pv && kind == 0) begin
                if (dir) exp_rise = CNT_W'(d);
                else     exp_fall = CNT_W'(d);
            end
            chk_all(ctx, pv && kind == 0 && dir, pv && kind == 0 && !dir,
                    pv && kind == 2, pv && kind == 1, (i >= S) && (i < outidx + S));
        end
        @(negedge clk);
        resp_in = stim_in;
        lvl     = stim_in;
        idle_cycles({ctx, " settle"}, S + 3);
    endtask

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b1;
        stim_in  = 1'b0;
        resp_in  = 1'b0;
        lvl      = 1'b0;
        exp_rise = '0;
        exp_fall = '0;

        // Reset state
        #17;
        chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles("post_reset", 3);

        // Directed: rise 2, fall 3, zero delay both ways
        run_trial("rise2", 2, -1);
        run_trial("fall3", 3, -1);
        run_trial("zero_rise", 0, -1);
        run_trial("zero_fall", 0, -1);

        // Swallowed pulse, then a response edge in IDLE must be ignored
        run_trial("swallow", -1, 2);
        @(negedge clk);
        resp_in = ~lvl;
        idle_cycles("idle_resp", S + 3);
        @(negedge clk);
        resp_in = lvl;
        idle_cycles("idle_resp_back", S + 3);

        // Timeout and the largest reportable delay, plus tie priorities
        run_trial("timeout", -1, -1);
        run_trial("max_dly", MAXD, -1);
        run_trial("max_dly_f", MAXD, -1);
        run_trial("resp_vs_revert", 4, 4);
        run_trial("revert_at_max", -1, MAXD);

        // Random trials
        for (int t = 0; t < 40; t++) begin
            int d, e;
            d = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 18));
            e = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 18)) : -1;
            run_trial("random", d, e);
        end

        // Enable dropped during a measurement
        @(negedge clk);
        stim_in = ~lvl;
        repeat (S + 1) @(posedge clk);
        #1;
        chk("en_busy_before", 32'(busy), 32'(1));
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk); #1;
        chk_all("en_drop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        resp_in = stim_in;
        lvl     = stim_in;
        idle_cycles("en_off", S + 3);
        @(negedge clk);
        enable = 1'b1;
        idle_cycles("en_on", 3);
        run_trial("after_en", 5, -1);

        // Reset asserted in WAIT_FALL
        if (lvl == 1'b0) run_trial("to_high", 1, -1);
        @(negedge clk);
        stim_in = 1'b0;
        repeat (S + 1) @(posedge clk);
        #1;
        chk("rst_busy_before", 32'(busy), 32'(1));
        #3;
        rst_n = 1'b0;
        #1;
        exp_rise = '0;
        exp_fall = '0;
        chk_all("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        stim_in = 1'b0;
        resp_in = 1'b0;
        lvl     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle_cycles("rst_release", 3);
        run_trial("after_rst", 6, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
